l2_spandex_chan_fifo_array: RTL and testbench
=============================================

// Module: l2_spandex_chan_fifo_array
// PURPOSE
// Parametrised bank of NUM_CH independent valid/ready elastic FIFOs for the flattened L2 message channels
// (fwd_in, rsp_in, req_out, rsp_out, fwd_out, ...). It sits between the NoC-facing flattened ports and l2_core.
// Each channel has per-channel flush, a selectable zero-latency bypass and live occupancy reporting.
// It also has saturating back-pressure counters, which drive the L2 stats channel in place of the constant-0 tie-off.
// PARAMETERS
// NUM_CH   5   number of independent channels
// WIDTH    64  payload bits per channel (packed message struct)
// DEPTH    4   entries per channel; power of 2, >= 2
// BYPASS   0   1: an empty FIFO with out_ready high forwards in_data in the same cycle
// STAT_W   16  width of each per-channel stall counter
// PORTS
// clk          in   1               clock, all state on rising edge
// rst          in   1               asynchronous, active-low reset
// in_valid     in   NUM_CH          producer valid, one bit per channel
// in_data      in   NUM_CH*WIDTH    producer payload, channel c at [c*WIDTH +: WIDTH]
// in_ready     out  NUM_CH          FIFO can accept
// out_valid    out  NUM_CH          head entry available
// out_data     out  NUM_CH*WIDTH    head payload, same packing as in_data
// out_ready    in   NUM_CH          consumer accepts
// flush        in   NUM_CH          discard all contents of the channel
// level        out  NUM_CH*(AW+1)   occupancy, AW=$clog2(DEPTH)
// stall_cnt    out  NUM_CH*STAT_W   cycles with in_valid & ~in_ready
// stats_clr    in   1               zero all stall counters
// BEHAVIOUR
// - Reset (rst=0, async): pointers, levels and stall_cnt go to 0; out_valid=0 and in_ready=1 on all channels.
//   Storage RAM is not reset.
// - Per channel, a ring buffer with wr_ptr/rd_ptr of AW bits that wrap DEPTH-1 -> 0. The level is AW+1 bits, 0..DEPTH.
// - in_ready = (level != DEPTH) & ~flush. It is independent of out_ready, so no ready->ready combinational path.
// - out_valid = (level != 0) & ~flush, or under BYPASS=1: (level==0) & in_valid & ~flush.
// - Push on in_valid & in_ready; pop on out_valid & out_ready.
//   Same-cycle push and pop leave the level unchanged and advance both pointers.
// - Latency with BYPASS=0: a word pushed in cycle t gives out_valid in t+1. Order is strict FIFO per channel.
// - Latency with BYPASS=1: with level==0, in_valid and out_ready, the word passes in cycle t, out_data=in_data,
//   with no write and no level change.
//   With level==0, in_valid and ~out_ready, the word is written normally; it shows as bypass out_valid in t and is held from the RAM in t+1.
// - Full: no push. A pop in the same cycle does not enable a push (in_ready already 0); in_ready rises the cycle after the pop.
// - Empty: out_data is don't-care; the bench must not check it.
// - Once out_valid is asserted, out_valid and out_data stay stable until the pop. Flush is the only exception.
// - flush[c]: in that cycle in_ready[c]=0 and out_valid[c]=0; the next cycle starts with level=0 and pointers=0.
//   A flush while data is present drops that data silently. A flush of one channel does not disturb the others.
// - stall_cnt[c] increments when in_valid & ~in_ready (flush cycles included) and saturates at 2^STAT_W-1.
//   stats_clr takes priority over an increment in the same cycle (the result is 0).
// - Channels are fully independent; there is no arbitration or shared state except stats_clr.
// - Reset asserted mid-transfer: contents are lost immediately. No partial output glitches beyond the async clear.
// TESTING
// - Reset, then ch0 pushes A,B,C,D back to back with out_ready=0 -> in_ready[0]=0 after D, level=4,
//   and stall_cnt increments by 1 per held 5th-word cycle.
// - Full ch0, with push and pop in the same cycle -> pop only, level 4->3, and in_ready rises the next cycle.
// - After that, pop 4 and push 4 across the pointer wrap -> the output order is unchanged.
// - BYPASS=1, ch1 empty, in_valid=out_ready=1, data 0xDEAD -> out_data=0xDEAD the same cycle and level stays 0.
//   With BYPASS=0, the same stimulus gives out_valid one cycle later.
// - ch2 holding 3 words, flush for 1 cycle while ch3 streams -> ch2 level=0 and out_valid=0 next cycle.
//   ch3 sequence is unaffected; a push to ch2 during the flush is not accepted.
// - STAT_W=4, stall ch4 for 20 cycles -> stall_cnt=15 (saturated); stats_clr together with a stall -> 0 next cycle.
// - Reset deasserted then asserted mid-stream with level=2 -> out_valid drops asynchronously and level reads 0 after release.

Source files
------------

// File: rtl/l2_spandex_chan_fifo_array_if.sv
// Channel bundle between the NoC-facing flattened ports and l2_core.
// master drives producer/consumer side; slave is the FIFO bank.
interface l2_spandex_chan_fifo_array_if #(
  parameter int NUM_CH = 5,
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH*WIDTH-1:0]    in_data;
  logic [NUM_CH-1:0]          in_ready;
  logic [NUM_CH-1:0]          out_valid;
  logic [NUM_CH*WIDTH-1:0]    out_data;
  logic [NUM_CH-1:0]          out_ready;
  logic [NUM_CH-1:0]          flush;
  logic [NUM_CH*(AW+1)-1:0]   level;
  logic [NUM_CH*STAT_W-1:0]   stall_cnt;
  logic                       stats_clr;

  modport master (
    output in_valid, in_data, out_ready,
    output flush, stats_clr,
    input  in_ready, out_valid, out_data,
    input  level, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    input  flush, stats_clr,
    output in_ready, out_valid, out_data,
    output level, stall_cnt
  );
endinterface

// File: rtl/l2_spandex_chan_fifo_array.sv
// Bank of independent valid/ready ring-buffer FIFOs for the L2 channels,
// with per-channel flush, optional bypass, occupancy and stall counters.
module l2_spandex_chan_fifo_array #(
  parameter int NUM_CH = 5,
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic rst,
  l2_spandex_chan_fifo_array_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic        BYP_EN = (BYPASS != 0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_lvl;
    logic [STAT_W-1:0] r_stall;

    logic             w_iv, w_or, w_fl;
    logic             w_empty, w_full;
    logic             w_ird, w_ovl, w_byp, w_thru;
    logic             w_push, w_pop, w_wr, w_rd;
    logic [WIDTH-1:0] w_din;

    assign w_iv  = bus.in_valid[c];
    assign w_or  = bus.out_ready[c];
    assign w_fl  = bus.flush[c];
    assign w_din = bus.in_data[c*WIDTH +: WIDTH];

    assign w_empty = (r_lvl == '0);
    assign w_full  = (r_lvl == L_FULL);

    // ready never looks at out_ready: no ready->ready path
    assign w_ird = ~w_full & ~w_fl;
    assign w_byp = BYP_EN & w_empty & w_iv & ~w_fl;
    assign w_ovl = (~w_empty & ~w_fl) | w_byp;

    assign w_push = w_iv & w_ird;
    assign w_pop  = w_ovl & w_or;

    // word passes straight through an empty FIFO without storage
    assign w_thru = w_byp & w_or;
    assign w_wr   = w_push & ~w_thru;
    assign w_rd   = w_pop & ~w_thru;

    assign bus.in_ready[c]  = w_ird;
    assign bus.out_valid[c] = w_ovl;
    assign bus.out_data[c*WIDTH +: WIDTH] =
      (BYP_EN && w_empty) ? w_din : r_mem[r_rp];
    assign bus.level[c*(AW+1) +: AW+1]    = r_lvl;
    assign bus.stall_cnt[c*STAT_W +: STAT_W] = r_stall;

    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= w_din;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_lvl <= '0;
      end else if (w_fl) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_lvl <= '0;
      end else begin
        if (w_wr) r_wp <= r_wp + AW'(1);
        if (w_rd) r_rp <= r_rp + AW'(1);
        if (w_wr && !w_rd)
          r_lvl <= r_lvl + (AW+1)'(1);
        else if (!w_wr && w_rd)
          r_lvl <= r_lvl - (AW+1)'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_stall <= '0;
      else if (bus.stats_clr)
        r_stall <= '0;
      else if (w_iv && !w_ird && !(&r_stall))
        r_stall <= r_stall + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_l2_spandex_chan_fifo_array.sv
// Bench for the L2 channel FIFO bank: a BYPASS=0 bank under a scoreboard,
// plus a BYPASS=1 bank for same-cycle forwarding.
module tb_l2_spandex_chan_fifo_array;
  localparam int NC = 5;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int SW = 4;
  localparam int AW = 2;

  typedef logic [W-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_spandex_chan_fifo_array_if #(
    .NUM_CH(NC), .WIDTH(W), .DEPTH(D), .STAT_W(SW)
  ) b0 ();
  l2_spandex_chan_fifo_array_if #(
    .NUM_CH(NC), .WIDTH(W), .DEPTH(D), .STAT_W(SW)
  ) b1 ();

  l2_spandex_chan_fifo_array #(
    .NUM_CH(NC), .WIDTH(W), .DEPTH(D),
    .BYPASS(0), .STAT_W(SW)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  l2_spandex_chan_fifo_array #(
    .NUM_CH(NC), .WIDTH(W), .DEPTH(D),
    .BYPASS(1), .STAT_W(SW)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] lv0(input int c);
    return b0.level[c*(AW+1) +: AW+1];
  endfunction
  function automatic logic [AW:0] lv1(input int c);
    return b1.level[c*(AW+1) +: AW+1];
  endfunction
  function automatic logic [SW-1:0] st0(input int c);
    return b0.stall_cnt[c*SW +: SW];
  endfunction
  function automatic word_t od0(input int c);
    return b0.out_data[c*W +: W];
  endfunction
  function automatic word_t od1(input int c);
    return b1.out_data[c*W +: W];
  endfunction

  word_t sb [NC][$];

  // handshakes are stable at negedge and complete on the next posedge
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) sb[c].delete();
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (b0.out_valid[c] && b0.out_ready[c]) begin
          if (sb[c].size() == 0)
            chk($sformatf("sb_unexp_ch%0d", c), 64'(sb[c].size()), 1);
          else
            chk($sformatf("order_ch%0d", c), od0(c), sb[c].pop_front());
        end
        if (b0.flush[c]) sb[c].delete();
        if (b0.in_valid[c] && b0.in_ready[c])
          sb[c].push_back(b0.in_data[c*W +: W]);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input int c);
    int k;
    for (k = 0; k < 12; k++) begin
      smp();
      if (!b0.out_valid[c]) break;
      nxt();
    end
    chk($sformatf("drain_to_ch%0d", c), 64'(k < 12), 1);
    chk($sformatf("drain_sb_ch%0d", c), 64'(sb[c].size()), 0);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    b0.in_valid = '0; b0.in_data = '0; b0.out_ready = '0;
    b0.flush = '0; b0.stats_clr = 1'b0;
    b1.in_valid = '0; b1.in_data = '0; b1.out_ready = '0;
    b1.flush = '0; b1.stats_clr = 1'b0;

    #3;
    chk("rst_level", 64'(b0.level), 0);
    chk("rst_in_ready", 64'(b0.in_ready), 64'h1f);
    chk("rst_out_valid", 64'(b0.out_valid), 0);
    chk("rst_stall", 64'(b0.stall_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    nxt();

    // fill ch0 to full, then hold a fifth word
    for (int i = 0; i < 4; i++) begin
      b0.in_valid[0] = 1'b1;
      b0.in_data[0 +: W] = W'(16'hA0 + i);
      nxt();
    end
    b0.in_data[0 +: W] = 16'hE0;
    smp();
    chk("full_level", lv0(0), 4);
    chk("full_in_ready", b0.in_ready[0], 0);
    chk("full_stall0", st0(0), 0);
    nxt(); smp();
    chk("full_stall1", st0(0), 1);
    nxt(); smp();
    chk("full_stall2", st0(0), 2);

    // full with push+pop pending: pop only
    nxt();
    b0.out_ready[0] = 1'b1;
    smp();
    chk("fpp_in_ready", b0.in_ready[0], 0);
    chk("fpp_out_valid", b0.out_valid[0], 1);
    nxt();
    b0.out_ready[0] = 1'b0;
    b0.in_valid[0] = 1'b0;
    smp();
    chk("fpp_level", lv0(0), 3);
    chk("fpp_in_ready_up", b0.in_ready[0], 1);
    chk("fpp_stall", st0(0), 4);

    // streaming across the pointer wrap
    nxt();
    for (int i = 0; i < 4; i++) begin
      b0.in_valid[0] = 1'b1;
      b0.out_ready[0] = 1'b1;
      b0.in_data[0 +: W] = W'(16'hC0 + i);
      nxt();
    end
    b0.in_valid[0] = 1'b0;
    drain(0);
    chk("wrap_level", lv0(0), 0);
    nxt();
    b0.out_ready[0] = 1'b0;

    // bypass vs registered latency on ch1
    b0.in_valid[1] = 1'b1; b0.in_data[W +: W] = 16'hDEAD;
    b1.in_valid[1] = 1'b1; b1.in_data[W +: W] = 16'hDEAD;
    b0.out_ready[1] = 1'b1; b1.out_ready[1] = 1'b1;
    smp();
    chk("byp_ov", b1.out_valid[1], 1);
    chk("byp_data", od1(1), 16'hDEAD);
    chk("byp_level", lv1(1), 0);
    chk("nobyp_ov_t", b0.out_valid[1], 0);
    nxt();
    b0.in_valid[1] = 1'b0; b1.in_valid[1] = 1'b0;
    smp();
    chk("nobyp_ov_t1", b0.out_valid[1], 1);
    chk("nobyp_data", od0(1), 16'hDEAD);
    chk("byp_ov_after", b1.out_valid[1], 0);
    chk("byp_level_after", lv1(1), 0);
    nxt();
    b1.in_valid[1] = 1'b1; b1.in_data[W +: W] = 16'hBEEF;
    b1.out_ready[1] = 1'b0;
    smp();
    chk("bypw_ov_t", b1.out_valid[1], 1);
    chk("bypw_data_t", od1(1), 16'hBEEF);
    nxt();
    b1.in_valid[1] = 1'b0;
    smp();
    chk("bypw_ov_t1", b1.out_valid[1], 1);
    chk("bypw_data_t1", od1(1), 16'hBEEF);
    chk("bypw_level", lv1(1), 1);
    nxt();
    b1.out_ready[1] = 1'b1;
    nxt(); smp();
    chk("bypw_drained", lv1(1), 0);
    chk("bypw_ov_end", b1.out_valid[1], 0);
    nxt();
    b0.out_ready[1] = 1'b0; b1.out_ready[1] = 1'b0;

    // flush ch2 holding 3 words while ch3 streams
    for (int i = 0; i < 3; i++) begin
      b0.in_valid[2] = 1'b1;
      b0.in_data[2*W +: W] = W'(16'h20 + i);
      nxt();
    end
    b0.in_valid[2] = 1'b0;
    b0.out_ready[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b0.in_valid[3] = 1'b1;
      b0.in_data[3*W +: W] = W'(16'h30 + i);
      b0.flush[2] = (i == 2);
      b0.in_valid[2] = (i == 2);
      b0.in_data[2*W +: W] = 16'h2F;
      smp();
      if (i == 2) begin
        chk("fl_in_ready", b0.in_ready[2], 0);
        chk("fl_out_valid", b0.out_valid[2], 0);
      end
      if (i == 3) begin
        chk("fl_level", lv0(2), 0);
        chk("fl_ov_next", b0.out_valid[2], 0);
        chk("fl_ch3_ready", b0.in_ready[3], 1);
      end
      nxt();
    end
    b0.in_valid[3] = 1'b0;
    drain(3);
    chk("fl_stall", st0(2), 1);
    chk("fl_sb2", 64'(sb[2].size()), 0);
    nxt();
    b0.out_ready[3] = 1'b0;

    // saturate ch4 stall counter, then clear under stall
    for (int i = 0; i < 4; i++) begin
      b0.in_valid[4] = 1'b1;
      b0.in_data[4*W +: W] = W'(16'h40 + i);
      nxt();
    end
    b0.in_data[4*W +: W] = 16'h4F;
    repeat (20) nxt();
    smp();
    chk("sat_stall", st0(4), 15);
    nxt(); smp();
    chk("sat_hold", st0(4), 15);
    nxt();
    b0.stats_clr = 1'b1;
    nxt();
    b0.stats_clr = 1'b0;
    smp();
    chk("clr_all", 64'(b0.stall_cnt), 0);
    nxt(); smp();
    chk("clr_then_inc", st0(4), 1);
    nxt();
    b0.in_valid[4] = 1'b0;

    // async reset mid-stream at level 2
    b0.out_ready[4] = 1'b1;
    nxt(); nxt();
    b0.out_ready[4] = 1'b0;
    smp();
    chk("pre_rst_level", lv0(4), 2);
    chk("pre_rst_ov", b0.out_valid[4], 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ov", b0.out_valid[4], 0);
    chk("arst_level", 64'(b0.level), 0);
    nxt(); nxt();
    rst = 1'b1;
    smp();
    chk("rel_level", 64'(b0.level), 0);
    chk("rel_in_ready", 64'(b0.in_ready), 64'h1f);
    chk("rel_ov", 64'(b0.out_valid), 0);
    nxt();
    b0.in_valid[0] = 1'b1;
    b0.in_data[0 +: W] = 16'h77;
    nxt();
    b0.in_valid[0] = 1'b0;
    smp();
    chk("post_ov", b0.out_valid[0], 1);
    chk("post_data", od0(0), 16'h77);
    nxt();
    b0.out_ready[0] = 1'b1;
    drain(0);
    nxt();
    b0.out_ready[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
